// File: rtl/pkt_write_arbiter_if.sv
// Bus bundle for pkt_write_arbiter: upstream port signals, output beat stage and status.
// The master modport is the side that owns the input ports and the downstream ready.
// The slave modport is the arbiter.
// weight_p exists only when WRR_WEIGHTS_EN is defined.
interface pkt_write_arbiter_if #(
    parameter int num_of_ports       = 16,
    parameter int arbiter_data_width = 256,
    parameter int weight_width       = 4
);
    localparam int port_width = (num_of_ports > 1) ? $clog2(num_of_ports) : 1;

    logic                                   sp0_wrr1;
    logic [num_of_ports-1:0]                vld;
    logic [num_of_ports-1:0]                sop;
    logic [num_of_ports-1:0]                eop;
    logic [num_of_ports*arbiter_data_width-1:0] data_in_p;
`ifdef WRR_WEIGHTS_EN
    logic [num_of_ports*weight_width-1:0]   weight_p;
`endif
    logic                                   out_ready;
    logic [num_of_ports-1:0]                next_data;
    logic [arbiter_data_width-1:0]          selected_data_out;
    logic                                   out_vld;
    logic                                   out_sop;
    logic                                   out_eop;
    logic [port_width-1:0]                  out_port;
    logic                                   busy;

`ifdef WRR_WEIGHTS_EN
    modport slave (
        input  sp0_wrr1, vld, sop, eop, data_in_p, weight_p, out_ready,
        output next_data, selected_data_out, out_vld, out_sop, out_eop, out_port, busy
    );
    modport master (
        output sp0_wrr1, vld, sop, eop, data_in_p, weight_p, out_ready,
        input  next_data, selected_data_out, out_vld, out_sop, out_eop, out_port, busy
    );
`else
    modport slave (
        input  sp0_wrr1, vld, sop, eop, data_in_p, out_ready,
        output next_data, selected_data_out, out_vld, out_sop, out_eop, out_port, busy
    );
    modport master (
        output sp0_wrr1, vld, sop, eop, data_in_p, out_ready,
        input  next_data, selected_data_out, out_vld, out_sop, out_eop, out_port, busy
    );
`endif
endinterface

// File: rtl/pkt_write_arbiter.sv
// Packet-aware N:1 write arbiter feeding the SRAM write datapath.
// A port wins on sop and keeps the grant until its eop beat is accepted.
// Beats leave through a single registered stage that honours out_ready.
// Strict priority (lowest index wins) or weighted round robin with per-port credits.
// Optional macro WRR_WEIGHTS_EN: credit reload comes from weight_p (0 counts as 1);
// without it every grant carries a credit of 1 (plain packet round robin).
module pkt_write_arbiter #(
    parameter int num_of_ports       = 16,
    parameter int arbiter_data_width = 256,
    parameter int weight_width       = 4
) (
    input logic                clk,
    input logic                rst,
    pkt_write_arbiter_if.slave bus
);
    localparam int port_width = (num_of_ports > 1) ? $clog2(num_of_ports) : 1;

    typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;

    state_t                          state_q, state_d;
    logic [port_width-1:0]           grant_q, grant_d;
    logic [port_width-1:0]           rr_ptr_q, rr_ptr_d;
    logic [weight_width-1:0]         credit_q, credit_d;
    logic                            out_vld_q, out_vld_d;
    logic                            out_sop_q, out_sop_d;
    logic                            out_eop_q, out_eop_d;
    logic [port_width-1:0]           out_port_q, out_port_d;
    logic [arbiter_data_width-1:0]   out_data_q, out_data_d;

    logic [num_of_ports-1:0]         elig;
    logic [num_of_ports-1:0]         pop;
    logic                            load;
    logic [port_width-1:0]           sp_winner;
    logic [port_width-1:0]           wrr_winner;
    logic [port_width-1:0]           wrr_idx;
    logic                            wrr_found;
    logic [port_width-1:0]           winner;
    logic [port_width-1:0]           ptr_after_grant;
    logic [weight_width-1:0]         reload_credit;

    assign elig   = bus.vld & bus.sop;
    assign winner = bus.sp0_wrr1 ? wrr_winner : sp_winner;
    assign ptr_after_grant = (int'(grant_q) == num_of_ports - 1) ? '0 : grant_q + port_width'(1);

`ifdef WRR_WEIGHTS_EN
    logic [weight_width-1:0] raw_weight;
    assign raw_weight    = bus.weight_p[int'(winner)*weight_width +: weight_width];
    assign reload_credit = (raw_weight == '0) ? weight_width'(1) : raw_weight;
`else
    assign reload_credit = weight_width'(1);
`endif

    // Strict priority: the lowest-indexed eligible port wins.
    always_comb begin
        sp_winner = '0;
        for (int i = num_of_ports - 1; i >= 0; i--) begin
            if (elig[i]) sp_winner = port_width'(i);
        end
    end

    // Round robin: first eligible port at or after the pointer, wrapping at N-1.
    always_comb begin
        wrr_winner = rr_ptr_q;
        wrr_found  = 1'b0;
        wrr_idx    = rr_ptr_q;
        for (int k = 0; k < num_of_ports; k++) begin
            wrr_idx = port_width'((int'(rr_ptr_q) + k) % num_of_ports);
            if (!wrr_found && elig[wrr_idx]) begin
                wrr_winner = wrr_idx;
                wrr_found  = 1'b1;
            end
        end
    end

    // FSM next state, grant/credit bookkeeping and output stage loading.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        credit_d   = credit_q;
        out_vld_d  = out_vld_q;
        out_sop_d  = out_sop_q;
        out_eop_d  = out_eop_q;
        out_port_d = out_port_q;
        out_data_d = out_data_q;
        pop        = '0;
        load       = !out_vld_q || bus.out_ready;
        if (load) out_vld_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|elig) state_d = ARB;
            end
            ARB: begin
                if (|elig) begin
                    grant_d = winner;
                    if (winner != grant_q || credit_q == '0) credit_d = reload_credit;
                    if (bus.sp0_wrr1) rr_ptr_d = winner;
                    state_d = XFER;
                end else begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                if (bus.vld[grant_q] && load) begin
                    pop[grant_q] = 1'b1;
                    out_vld_d    = 1'b1;
                    out_sop_d    = bus.sop[grant_q];
                    out_eop_d    = bus.eop[grant_q];
                    out_port_d   = grant_q;
                    out_data_d   = bus.data_in_p[int'(grant_q)*arbiter_data_width +: arbiter_data_width];
                    if (bus.eop[grant_q]) begin
                        if (credit_q <= weight_width'(1)) begin
                            credit_d = '0;
                            rr_ptr_d = ptr_after_grant;
                        end else begin
                            credit_d = credit_q - weight_width'(1);
                        end
                        state_d = (|(elig & ~pop)) ? ARB : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, grant, credit and output registers; reset abandons any packet in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            credit_q   <= '0;
            out_vld_q  <= 1'b0;
            out_sop_q  <= 1'b0;
            out_eop_q  <= 1'b0;
            out_port_q <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            credit_q   <= credit_d;
            out_vld_q  <= out_vld_d;
            out_sop_q  <= out_sop_d;
            out_eop_q  <= out_eop_d;
            out_port_q <= out_port_d;
            out_data_q <= out_data_d;
        end
    end

    assign bus.next_data         = pop;
    assign bus.selected_data_out = out_data_q;
    assign bus.out_vld           = out_vld_q;
    assign bus.out_sop           = out_sop_q;
    assign bus.out_eop           = out_eop_q;
    assign bus.out_port          = out_port_q;
    assign bus.busy              = (state_q != IDLE) || out_vld_q;
endmodule

// File: tb/tb_pkt_write_arbiter.sv
// Directed testbench for pkt_write_arbiter.
// Each upstream port is a small packet source that advances on next_data;
// accepted output beats are captured and compared against hand-written sequences.
// Beat payload = {port[7:0], packet index[7:0], beat index[15:0]}.
// The weighted round robin scenario runs only when WRR_WEIGHTS_EN is defined.
module tb_pkt_write_arbiter;
    localparam int N  = 16;
    localparam int W  = 32;
    localparam int WW = 4;
    localparam int PW = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pkt_write_arbiter_if #(.num_of_ports(N), .arbiter_data_width(W), .weight_width(WW)) bus ();

    pkt_write_arbiter #(.num_of_ports(N), .arbiter_data_width(W), .weight_width(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cmp_count = 0;
    int err_count = 0;

    int pkts_left [N];
    int pkt_len   [N];
    int beat_idx  [N];
    int pkt_cnt   [N];
    bit hold      [N];
    int weight    [N];

    logic [N-1:0]  last_pops;
    logic [PW-1:0] cap_port [$];
    logic [W-1:0]  cap_data [$];
    logic          cap_sop  [$];
    logic          cap_eop  [$];

    function automatic logic [W-1:0] enc(input int p, input int k, input int b);
        return {8'(p), 8'(k), 16'(b)};
    endfunction

    // Present each source's current beat on the bus.
    task automatic drive_sources();
        logic [N-1:0]   v;
        logic [N-1:0]   s;
        logic [N-1:0]   e;
        logic [N*W-1:0] d;
        v = '0;
        s = '0;
        e = '0;
        d = '0;
        for (int i = 0; i < N; i++) begin
            if (pkts_left[i] > 0) begin
                v[i] = !hold[i];
                s[i] = (beat_idx[i] == 0);
                e[i] = (beat_idx[i] == pkt_len[i] - 1);
            end
            d[i*W +: W] = enc(i, pkt_cnt[i], beat_idx[i]);
        end
        bus.vld       = v;
        bus.sop       = s;
        bus.eop       = e;
        bus.data_in_p = d;
`ifdef WRR_WEIGHTS_EN
        begin
            logic [N*WW-1:0] w;
            w = '0;
            for (int i = 0; i < N; i++) w[i*WW +: WW] = WW'(weight[i]);
            bus.weight_p = w;
        end
`endif
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            pkts_left[i] = 0;
            pkt_len[i]   = 1;
            beat_idx[i]  = 0;
            pkt_cnt[i]   = 0;
            hold[i]      = 1'b0;
            weight[i]    = 1;
        end
        drive_sources();
    endtask

    // One clock: sample pops/output at negedge, then advance sources after the edge.
    task automatic step();
        logic [N-1:0] pops;
        @(negedge clk);
        pops = bus.next_data;
        if (bus.out_vld && bus.out_ready) begin
            cap_port.push_back(bus.out_port);
            cap_data.push_back(bus.selected_data_out);
            cap_sop.push_back(bus.out_sop);
            cap_eop.push_back(bus.out_eop);
        end
        @(posedge clk);
        #1;
        last_pops = pops;
        for (int i = 0; i < N; i++) begin
            if (pops[i]) begin
                if (beat_idx[i] == pkt_len[i] - 1) begin
                    beat_idx[i]  = 0;
                    pkts_left[i] = pkts_left[i] - 1;
                    pkt_cnt[i]   = pkt_cnt[i] + 1;
                end else begin
                    beat_idx[i] = beat_idx[i] + 1;
                end
            end
        end
        drive_sources();
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (cap_port.size() < n && c < budget) begin
            step();
            c++;
        end
        cmp_count++;
        if (cap_port.size() < n) begin
            err_count++;
            $display("[TB] FAIL %s_timeout: got %0d beats, expected %0d", tag, cap_port.size(), n);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_sources();
        bus.out_ready = 1'b1;
        bus.sp0_wrr1  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        last_pops = '0;
        cap_port.delete();
        cap_data.delete();
        cap_sop.delete();
        cap_eop.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_sources();
        pkts_left[0] = 1;
        drive_sources();
        bus.out_ready = 1'b1;
        bus.sp0_wrr1  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmp_count++; if (bus.out_vld !== 1'b0) begin err_count++; $display("[TB] FAIL reset_out_vld: got %b, expected 0", bus.out_vld); end
        cmp_count++; if (bus.out_sop !== 1'b0) begin err_count++; $display("[TB] FAIL reset_out_sop: got %b, expected 0", bus.out_sop); end
        cmp_count++; if (bus.out_eop !== 1'b0) begin err_count++; $display("[TB] FAIL reset_out_eop: got %b, expected 0", bus.out_eop); end
        cmp_count++; if (bus.out_port !== '0) begin err_count++; $display("[TB] FAIL reset_out_port: got %0d, expected 0", bus.out_port); end
        cmp_count++; if (bus.selected_data_out !== '0) begin err_count++; $display("[TB] FAIL reset_data: got %h, expected 0", bus.selected_data_out); end
        cmp_count++; if (bus.busy !== 1'b0) begin err_count++; $display("[TB] FAIL reset_busy: got %b, expected 0", bus.busy); end
        cmp_count++; if (bus.next_data !== '0) begin err_count++; $display("[TB] FAIL reset_next_data: got %h, expected 0", bus.next_data); end
    endtask

    task automatic test_strict_priority();
        int exp_port [4] = '{3, 3, 7, 7};
        int exp_beat [4] = '{0, 1, 0, 1};
        do_reset();
        pkts_left[3] = 1; pkt_len[3] = 2;
        pkts_left[7] = 1; pkt_len[7] = 2;
        drive_sources();
        run_until(4, 40, "sp");
        for (int k = 0; k < 4; k++) begin
            cmp_count++;
            if (k >= cap_port.size()) begin
                err_count++;
                $display("[TB] FAIL sp_beat[%0d]: got nothing, expected port %0d", k, exp_port[k]);
            end else begin
                if (cap_port[k] !== PW'(exp_port[k]) || cap_data[k] !== enc(exp_port[k], 0, exp_beat[k])) begin
                    err_count++;
                    $display("[TB] FAIL sp_beat[%0d]: got port %0d data %h, expected port %0d data %h",
                             k, cap_port[k], cap_data[k], exp_port[k], enc(exp_port[k], 0, exp_beat[k]));
                end
                cmp_count++;
                if (cap_sop[k] !== (exp_beat[k] == 0) || cap_eop[k] !== (exp_beat[k] == 1)) begin
                    err_count++;
                    $display("[TB] FAIL sp_flags[%0d]: got sop %b eop %b, expected sop %b eop %b",
                             k, cap_sop[k], cap_eop[k], exp_beat[k] == 0, exp_beat[k] == 1);
                end
            end
        end
    endtask

    task automatic test_wrr_plain();
        int exp_port [6] = '{0, 1, 2, 0, 1, 2};
        int exp_pkt  [6] = '{0, 0, 0, 1, 1, 1};
        do_reset();
        bus.sp0_wrr1 = 1'b1;
        for (int i = 0; i < 3; i++) pkts_left[i] = 2;
        drive_sources();
        run_until(6, 60, "wrr");
        for (int k = 0; k < 6; k++) begin
            cmp_count++;
            if (k >= cap_port.size()) begin
                err_count++;
                $display("[TB] FAIL wrr_beat[%0d]: got nothing, expected port %0d", k, exp_port[k]);
            end else if (cap_port[k] !== PW'(exp_port[k]) || cap_data[k] !== enc(exp_port[k], exp_pkt[k], 0)) begin
                err_count++;
                $display("[TB] FAIL wrr_beat[%0d]: got port %0d data %h, expected port %0d data %h",
                         k, cap_port[k], cap_data[k], exp_port[k], enc(exp_port[k], exp_pkt[k], 0));
            end
        end
    endtask

`ifdef WRR_WEIGHTS_EN
    task automatic test_wrr_weights();
        int exp_port [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        int exp_pkt  [8] = '{0, 1, 2, 0, 3, 4, 5, 1};
        do_reset();
        bus.sp0_wrr1 = 1'b1;
        weight[0] = 3; pkts_left[0] = 6;
        weight[1] = 1; pkts_left[1] = 2;
        drive_sources();
        run_until(8, 80, "wrrw");
        for (int k = 0; k < 8; k++) begin
            cmp_count++;
            if (k >= cap_port.size()) begin
                err_count++;
                $display("[TB] FAIL wrrw_beat[%0d]: got nothing, expected port %0d", k, exp_port[k]);
            end else if (cap_port[k] !== PW'(exp_port[k]) || cap_data[k] !== enc(exp_port[k], exp_pkt[k], 0)) begin
                err_count++;
                $display("[TB] FAIL wrrw_beat[%0d]: got port %0d data %h, expected port %0d data %h",
                         k, cap_port[k], cap_data[k], exp_port[k], enc(exp_port[k], exp_pkt[k], 0));
            end
        end
    endtask
`endif

    task automatic test_backpressure();
        do_reset();
        pkts_left[4] = 1; pkt_len[4] = 4;
        drive_sources();
        run_until(1, 20, "bp_first");
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cmp_count++;
            if (bus.out_vld !== 1'b1 || bus.selected_data_out !== enc(4, 0, 1)) begin
                err_count++;
                $display("[TB] FAIL bp_hold[%0d]: got vld %b data %h, expected vld 1 data %h",
                         c, bus.out_vld, bus.selected_data_out, enc(4, 0, 1));
            end
            step();
            cmp_count++;
            if (last_pops !== '0) begin
                err_count++;
                $display("[TB] FAIL bp_pop[%0d]: got %h, expected 0", c, last_pops);
            end
        end
        bus.out_ready = 1'b1;
        run_until(4, 20, "bp");
        for (int k = 0; k < 4; k++) begin
            cmp_count++;
            if (k >= cap_port.size()) begin
                err_count++;
                $display("[TB] FAIL bp_beat[%0d]: got nothing, expected beat %0d", k, k);
            end else if (cap_port[k] !== PW'(4) || cap_data[k] !== enc(4, 0, k)) begin
                err_count++;
                $display("[TB] FAIL bp_beat[%0d]: got port %0d data %h, expected port 4 data %h",
                         k, cap_port[k], cap_data[k], enc(4, 0, k));
            end
        end
    endtask

    task automatic test_bubble();
        int exp_port [5] = '{5, 5, 5, 5, 2};
        int exp_beat [5] = '{0, 1, 2, 3, 0};
        do_reset();
        pkts_left[5] = 1; pkt_len[5] = 4;
        drive_sources();
        run_until(1, 20, "bub_first");
        pkts_left[2] = 1;
        hold[5] = 1'b1;
        drive_sources();
        for (int c = 0; c < 3; c++) begin
            step();
            cmp_count++;
            if (last_pops !== '0 || bus.busy !== 1'b1) begin
                err_count++;
                $display("[TB] FAIL bub_hold[%0d]: got pops %h busy %b, expected pops 0 busy 1", c, last_pops, bus.busy);
            end
        end
        hold[5] = 1'b0;
        drive_sources();
        run_until(5, 30, "bub");
        for (int k = 0; k < 5; k++) begin
            cmp_count++;
            if (k >= cap_port.size()) begin
                err_count++;
                $display("[TB] FAIL bub_beat[%0d]: got nothing, expected port %0d", k, exp_port[k]);
            end else if (cap_port[k] !== PW'(exp_port[k]) || cap_data[k] !== enc(exp_port[k], 0, exp_beat[k])) begin
                err_count++;
                $display("[TB] FAIL bub_beat[%0d]: got port %0d data %h, expected port %0d data %h",
                         k, cap_port[k], cap_data[k], exp_port[k], enc(exp_port[k], 0, exp_beat[k]));
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        pkts_left[6] = 1; pkt_len[6] = 4;
        drive_sources();
        run_until(1, 20, "rm_first");
        rst = 1'b1;
        @(posedge clk);
        #1;
        cmp_count++;
        if (bus.out_vld !== 1'b0 || bus.busy !== 1'b0 || bus.next_data !== '0 ||
            bus.selected_data_out !== '0 || bus.out_port !== '0) begin
            err_count++;
            $display("[TB] FAIL rm_reset: got vld %b busy %b pops %h data %h port %0d, expected all 0",
                     bus.out_vld, bus.busy, bus.next_data, bus.selected_data_out, bus.out_port);
        end
        clear_sources();
        cap_port.delete();
        cap_data.delete();
        cap_sop.delete();
        cap_eop.delete();
        rst = 1'b0;
        pkts_left[1] = 1; pkt_len[1] = 2;
        drive_sources();
        run_until(2, 20, "rm");
        for (int k = 0; k < 2; k++) begin
            cmp_count++;
            if (k >= cap_port.size()) begin
                err_count++;
                $display("[TB] FAIL rm_beat[%0d]: got nothing, expected port 1", k);
            end else if (cap_port[k] !== PW'(1) || cap_data[k] !== enc(1, 0, k) ||
                         cap_sop[k] !== (k == 0) || cap_eop[k] !== (k == 1)) begin
                err_count++;
                $display("[TB] FAIL rm_beat[%0d]: got port %0d data %h sop %b eop %b, expected port 1 data %h sop %b eop %b",
                         k, cap_port[k], cap_data[k], cap_sop[k], cap_eop[k], enc(1, 0, k), k == 0, k == 1);
            end
        end
    endtask

    initial begin
        last_pops = '0;
        test_reset();
        test_strict_priority();
        test_wrr_plain();
`ifdef WRR_WEIGHTS_EN
        test_wrr_weights();
`endif
        test_backpressure();
        test_bubble();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
